// File: rtl/intr_ctrl_if.sv
// CPU-side port bundle for intr_ctrl: register access, read data and the
// interrupt request/acknowledge handshake.
interface intr_ctrl_if;
  logic [15:0] port_id;
  logic [15:0] out_port;
  logic        write_strobe;
  logic        read_strobe;
  logic        interrupt_ack;
  logic [15:0] data_out;
  logic        interrupt;
  logic        in_service;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  data_out, interrupt, in_service
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output data_out, interrupt, in_service
  );
endinterface

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: synchronised edge/level sources, MASK /
// PENDING / STATUS / EOI registers and an IDLE -> REQ -> SERVICE handshake.
module intr_ctrl #(
  parameter int unsigned        NUM_SRC     = 8,
  parameter logic [15:0]        BASE_ADDR   = 16'h0040,
  parameter logic [NUM_SRC-1:0] EDGE_SRC    = '1,
  parameter int unsigned        ACK_TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  intr_ctrl_if.slave         bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

  localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

  logic [NUM_SRC-1:0] sync1, sync2, sync2_d;
  logic [NUM_SRC-1:0] mask_q, pend_q;
  logic [NUM_SRC-1:0] pending, active, rise, first_oh, w1c, ack_clr;
  logic [3:0]         first_idx, vector_q;
  logic               valid_q, timeout_q, interrupt_q, ack_take;
  logic [15:0]        cnt, rdata;
  state_e             state;

  wire sel_mask = (bus.port_id == BASE_ADDR);
  wire sel_pend = (bus.port_id == BASE_ADDR + 16'd1);
  wire sel_stat = (bus.port_id == BASE_ADDR + 16'd2);
  wire sel_eoi  = (bus.port_id == BASE_ADDR + 16'd3);
  wire wr_mask  = bus.write_strobe & sel_mask;
  wire wr_pend  = bus.write_strobe & sel_pend;
  wire wr_eoi   = bus.write_strobe & sel_eoi;

  // Level sources bypass the pending flop and show the synchronised input.
  assign pending  = (pend_q & EDGE_SRC) | (sync2 & ~EDGE_SRC);
  assign active   = pending & mask_q;
  assign rise     = sync2 & ~sync2_d & EDGE_SRC;
  assign first_oh = active & (-active);
  assign ack_take = (state == S_REQ) & bus.interrupt_ack & (|active);
  assign w1c      = wr_pend ? bus.out_port[NUM_SRC-1:0] : '0;
  assign ack_clr  = ack_take ? first_oh : '0;

  always_comb begin
    // NOTE: default first so no path through the loop leaves first_idx unassigned (no latch).
    first_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) first_idx = 4'(i);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_mask)      rdata = 16'(mask_q);
    else if (sel_pend) rdata = 16'(pending);
    else if (sel_stat) rdata = {valid_q, timeout_q, 10'b0, vector_q};
  end

  assign bus.data_out   = rdata;
  assign bus.interrupt  = interrupt_q;
  assign bus.in_service = (state == S_SERVICE);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // A new rise beats a same-cycle W1C or acknowledge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      if (wr_mask) mask_q <= bus.out_port[NUM_SRC-1:0];
      pend_q <= ((pend_q & ~(w1c | ack_clr)) | rise) & EDGE_SRC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      interrupt_q <= 1'b0;
      cnt         <= '0;
      vector_q    <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (wr_eoi) timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|active) begin
            state       <= S_REQ;
            interrupt_q <= 1'b1;
            cnt         <= '0;
          end
        end
        S_REQ: begin
          if (ack_take) begin
            vector_q    <= first_idx;
            valid_q     <= 1'b1;
            interrupt_q <= 1'b0;
            state       <= S_SERVICE;
          end else if (!(|active)) begin
            interrupt_q <= 1'b0;
            state       <= S_IDLE;
          end else if (!interrupt_q) begin
            // One-cycle gap after a timeout: re-raise with a fresh count.
            interrupt_q <= 1'b1;
            cnt         <= '0;
          end else if (cnt == CNT_LAST) begin
            interrupt_q <= 1'b0;
            timeout_q   <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SERVICE: begin
          if (wr_eoi) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read strobe has no side effects; upper write-data bits are don't-care.
  logic unused_ok;
  assign unused_ok = ^{bus.read_strobe, bus.out_port};

endmodule
